// File: rtl/memseq_pkg.sv
// Shared types for the memory request sequencer: request entry, FSM state, default widths.
package memseq_pkg;
    localparam int MS_ADDR_W = 4;
    localparam int MS_DATA_W = 32;

    typedef struct packed {
        logic                 wr;
        logic [MS_ADDR_W-1:0] addr;
        logic [MS_DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RSP} state_e;
endpackage

// File: rtl/memseq_fifo.sv
// Synchronous request FIFO of req_t entries; push into a full FIFO or pop from an empty one is ignored.
module memseq_fifo
    import memseq_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  req_t        din,
    output req_t        dout,
    output logic        full,
    output logic        empty,
    output logic [PW:0] count
);
    req_t          mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mem_req_sequencer.sv
// Queues host read/write requests and issues them one at a time on the memory bus, one read outstanding.
// MEMSEQ_PERF_EN adds saturating perf_wr_cnt/perf_rd_cnt bus-cycle counters.
module mem_req_sequencer
    import memseq_pkg::*;
#(
    parameter int ADDR_W     = MS_ADDR_W,
    parameter int DATA_W     = MS_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              bus_wr,
    output logic              bus_rd,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
`ifdef MEMSEQ_PERF_EN
    ,
    output logic [15:0]       perf_wr_cnt,
    output logic [15:0]       perf_rd_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state;
    req_t          fifo_din, head;
    logic          fifo_full, fifo_empty, push, pop;
    logic [CW-1:0] fifo_count;

    assign req_ready = !fifo_full && !rst;
    assign push      = req_valid && req_ready;
    assign fifo_din  = {req_wr, req_addr, req_wdata};
    assign busy      = !rst && (fifo_count != '0 || state != IDLE);

    // Dequeue only when the bus is free: idle, after a write strobe, or as the response is taken.
    assign pop = !fifo_empty && (state == IDLE || (state == ISSUE && bus_wr) ||
                                 (state == RSP && rsp_ready));

    memseq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_wr    <= 1'b0;
            bus_rd    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
        end else begin
            // Strobes are single-cycle; a pop re-arms them for the popped entry.
            bus_wr <= 1'b0;
            bus_rd <= 1'b0;
            if (pop) begin
                bus_wr   <= head.wr;
                bus_rd   <= !head.wr;
                bus_addr <= head.addr;
                if (head.wr) bus_wdata <= head.wdata;
            end
            case (state)
                IDLE:    if (pop) state <= ISSUE;
                ISSUE:   if (!pop) state <= bus_wr ? IDLE : RD_WAIT;
                RD_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= bus_rdata;
                    rsp_addr  <= bus_addr;
                    state     <= RSP;
                end
                RSP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= pop ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEMSEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_wr_cnt <= '0;
            perf_rd_cnt <= '0;
        end else begin
            if (bus_wr && perf_wr_cnt != 16'hFFFF) perf_wr_cnt <= perf_wr_cnt + 16'd1;
            if (bus_rd && perf_rd_cnt != 16'hFFFF) perf_rd_cnt <= perf_rd_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer with a 16x32 memory model and an in-order read scoreboard.
module tb_mem_req_sequencer;
    localparam int AW = 4, DW = 32, DEPTH = 4;

    logic          clk = 1'b0, rst;
    logic          req_valid, req_ready, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_rdata;
    logic          bus_wr, bus_rd;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic          busy;
`ifdef MEMSEQ_PERF_EN
    logic [15:0]   perf_wr_cnt, perf_rd_cnt;
`endif

    always #5 clk = ~clk;

    mem_req_sequencer #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .busy(busy)
`ifdef MEMSEQ_PERF_EN
        , .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt)
`endif
    );

    // Memory stage: registered read data, never reset.
    logic [DW-1:0] mem [16];
    initial bus_rdata = '0;
    always @(posedge clk) begin
        if (bus_wr) mem[bus_addr] <= bus_wdata;
        if (bus_rd) bus_rdata <= mem[bus_addr];
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: requests are applied in acceptance order, so a read's answer is
    // whatever the model memory holds when the read is accepted.
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [16];

    int rsp_mode = 0;  // 0: always ready, 1: never ready, 2: random
    initial rsp_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    int n_rsp = 0, wr_cyc = 0, rd_cyc = 0, wr_run = 0, max_run = 0, both_err = 0, rsp_vcyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (bus_wr && bus_rd) both_err++;
        if (bus_wr) begin
            wr_cyc++;
            wr_run++;
            if (wr_run > max_run) max_run = wr_run;
        end else wr_run = 0;
        if (bus_rd) rd_cyc++;
        if (rsp_valid) rsp_vcyc++;
        if (rsp_valid && rsp_ready && !rst) begin
            n_rsp++;
            if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_addr", rsp_addr, e.a);
                chk("rsp_rdata", rsp_rdata, e.d);
            end
        end
    end

    task automatic push_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int t = 0;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("push_timeout", 0, 1);
        else if (wr) ref_mem[a] = d;
        else exp_q.push_back('{a, ref_mem[a]});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic done = 1'b0;
        for (int t = 0; t < 2000 && !done; t++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && exp_q.size() == 0) done = 1'b1;
        end
        chk(tag, done, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int edges, pushed, reads, r0, rd0, v0, w0;
        logic full_seen, seen;
        logic [DW-1:0] snap;
        logic [AW-1:0] ra;
        logic rw;

        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready_low", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_bus_wr", bus_wr, 0);
        chk("rst_bus_rd", bus_rd, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;

        // Write then read with empty queue: response 3 edges after read handshake, 1 cycle wide.
        push_req(1'b1, 4'd3, 32'hDEADBEEF);
        wait_idle("t1_wr_idle");
        push_req(1'b0, 4'd3, '0);
        edges = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid) begin edges = n; break; end
        end
        chk("t1_latency", edges, 3);
        chk("t1_rsp_addr", rsp_addr, 3);
        chk("t1_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_rsp_pulse", rsp_valid, 0);
        wait_idle("t1_idle");

        // Back-to-back writes stream one per cycle; reads return them in order.
        max_run = 0; w0 = wr_cyc;
        for (int i = 0; i < 4; i++) push_req(1'b1, i[AW-1:0], 32'(10 + i));
        wait_idle("t2_wr_idle");
        chk("t2_wr_run", max_run, 4);
        chk("t2_wr_cycles", wr_cyc - w0, 4);
        r0 = n_rsp;
        for (int i = 0; i < 4; i++) push_req(1'b0, i[AW-1:0], '0);
        wait_idle("t2_rd_idle");
        chk("t2_rsp_cnt", n_rsp - r0, 4);

        // Back-pressure: one read outstanding, FIFO fills, response held stable.
        rsp_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        rd0 = rd_cyc; r0 = n_rsp; pushed = 0; full_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_wr = 1'b0; req_addr = i[AW-1:0];
            @(negedge clk);
            if (!req_ready) begin full_seen = 1'b1; break; end
            exp_q.push_back('{i[AW-1:0], ref_mem[i[AW-1:0]]});
            pushed++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("t3_full", full_seen, 1);
        chk("t3_pushed", pushed, DEPTH + 1);
        repeat (3) @(negedge clk);
        snap = rsp_rdata;
        repeat (8) @(negedge clk);
        chk("t3_rsp_held", rsp_valid, 1);
        chk("t3_rsp_stable", rsp_rdata, snap);
        chk("t3_one_rd", rd_cyc - rd0, 1);
        @(posedge clk); #1;
        rsp_mode = 0;
        wait_idle("t3_idle");
        chk("t3_rsp_cnt", n_rsp - r0, DEPTH + 1);
        chk("t3_rd_total", rd_cyc - rd0, DEPTH + 1);

        // Reset while bus_rd is high: everything clears and the read never answers.
        push_req(1'b0, 4'd5, '0);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (bus_rd) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("t4_saw_rd", seen, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        chk("t4_bus_rd", bus_rd, 0);
        chk("t4_bus_wr", bus_wr, 0);
        chk("t4_bus_addr", bus_addr, 0);
        chk("t4_bus_wdata", bus_wdata, 0);
        chk("t4_rsp_valid", rsp_valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ready_in_rst", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        v0 = rsp_vcyc;
        repeat (10) @(negedge clk);
        chk("t4_no_rsp", rsp_vcyc - v0, 0);
        chk("t4_ready", req_ready, 1);
        chk("t4_idle", busy, 0);
        @(posedge clk); #1;

        // Random mix with random response back-pressure.
        rsp_mode = 2; reads = 0; r0 = n_rsp;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            rw = 1'($urandom_range(0, 1));
            ra = AW'($urandom_range(0, 15));
            if (!rw) reads++;
            push_req(rw, ra, $urandom);
        end
        wait_idle("t5_idle");
        chk("t5_rsp_cnt", n_rsp - r0, reads);
        chk("t5_no_overlap", both_err, 0);
        rsp_mode = 0;
        repeat (2) @(posedge clk);
        #1;

`ifdef MEMSEQ_PERF_EN
        do_reset();
        for (int i = 0; i < 5; i++) push_req(1'b1, i[AW-1:0], 32'(100 + i));
        for (int i = 0; i < 3; i++) push_req(1'b0, i[AW-1:0], '0);
        wait_idle("t6_idle");
        chk("t6_perf_wr", perf_wr_cnt, 5);
        chk("t6_perf_rd", perf_rd_cnt, 3);
        do_reset();
        @(negedge clk);
        chk("t6_perf_wr_rst", perf_wr_cnt, 0);
        chk("t6_perf_rd_rst", perf_rd_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
